rtc_bus_arbiter: RTL and testbench

// Sequences and shares the single 8-bit RTC address/data bus between four bus machines:

---
 rtl/rtc_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: shares the RTC address/data bus between the init, write,
// crono and read machines. Exactly one grant is high at a time, init always
// runs first after reset, every release is followed by a turnaround gap, and
// a hung owner is evicted after TIMEOUT cycles.
module rtc_bus_arbiter #(
  parameter int TURN_CYCLES = 2,
  parameter int TIMEOUT     = 1023,
  parameter int CNT_W       = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_write,
  input  logic       req_crono,
  input  logic       req_read,
  input  logic       done_init,
  input  logic       done_write,
  input  logic       done_crono,
  input  logic       done_read,
  input  logic       clr_err,
  output logic       gnt_init,
  output logic       gnt_write,
  output logic       gnt_crono,
  output logic       gnt_read,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    IDLE  = 2'd1,
    GRANT = 2'd2,
    TURN  = 2'd3
  } state_t;

  // Terminal counts: the counter starts at zero on entry to GRANT/TURN,
  // so the last cycle of each phase is count == length-1.
  localparam logic [CNT_W-1:0] CNT_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_TURN_LAST    = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE          = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       gnt_reg, gnt_next;
  logic [1:0]       owner_reg, owner_next;
  logic             err_reg, err_next;

  logic [3:0]       done_vec;
  logic             owner_done;
  logic             set_err;

  // Bit index matches the owner encoding: 0 init, 1 write, 2 crono, 3 read.
  assign done_vec   = {done_read, done_crono, done_write, done_init};
  assign owner_done = done_vec[owner_reg];

  // State, counter, grants, owner and sticky error register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= BOOT;
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      owner_reg <= 2'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      owner_reg <= owner_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic: arbitration, hold/timeout and turnaround sequencing.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gnt_next   = gnt_reg;
    owner_next = owner_reg;
    set_err    = 1'b0;

    case (state_reg)
      BOOT: begin
        // Init is granted unconditionally on the first edge after reset.
        gnt_next   = 4'b0001;
        owner_next = 2'd0;
        cnt_next   = '0;
        state_next = GRANT;
      end

      IDLE: begin
        // Fixed priority write > crono > read; requests are levels only.
        cnt_next = '0;
        if (req_write) begin
          gnt_next   = 4'b0010;
          owner_next = 2'd1;
          state_next = GRANT;
        end else if (req_crono) begin
          gnt_next   = 4'b0100;
          owner_next = 2'd2;
          state_next = GRANT;
        end else if (req_read) begin
          gnt_next   = 4'b1000;
          owner_next = 2'd3;
          state_next = GRANT;
        end
      end

      GRANT: begin
        // Owner's done takes precedence over a timeout in the same cycle.
        if (owner_done) begin
          gnt_next   = '0;
          cnt_next   = '0;
          state_next = TURN;
        end else if (cnt_reg == CNT_TIMEOUT_LAST) begin
          gnt_next   = '0;
          cnt_next   = '0;
          set_err    = 1'b1;
          state_next = TURN;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      TURN: begin
        gnt_next = '0;
        if (cnt_reg == CNT_TURN_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        gnt_next   = '0;
        cnt_next   = '0;
        state_next = BOOT;
      end
    endcase
  end

  // Sticky timeout flag: a new timeout beats a simultaneous clear.
  always_comb begin
    err_next = err_reg;
    if (set_err) begin
      err_next = 1'b1;
    end else if (clr_err) begin
      err_next = 1'b0;
    end
  end

  assign gnt_init    = gnt_reg[0];
  assign gnt_write   = gnt_reg[1];
  assign gnt_crono   = gnt_reg[2];
  assign gnt_read    = gnt_reg[3];
  assign owner       = owner_reg;
  assign bus_busy    = |gnt_reg;
  assign timeout_err = err_reg;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: a driver plays the four bus machines with random
// requests, done timing, spurious dones and error clears; each grant it expects
// is pushed as a record (owner, hold length, error flag, gap) and a monitor
// pops and compares whenever a grant interval ends on the bus.
module tb_rtc_bus_arbiter;

  localparam int TURN_CYCLES = 2;
  localparam int TIMEOUT     = 8;
  localparam int CNT_W       = 4;
  localparam int NTXN        = 60;

  logic       clk;
  logic       reset;
  logic       req_write, req_crono, req_read;
  logic       done_init, done_write, done_crono, done_read;
  logic       clr_err;
  logic       gnt_init, gnt_write, gnt_crono, gnt_read;
  logic [1:0] owner;
  logic       bus_busy;
  logic       timeout_err;

  rtc_bus_arbiter #(
    .TURN_CYCLES(TURN_CYCLES),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_write  (req_write),
    .req_crono  (req_crono),
    .req_read   (req_read),
    .done_init  (done_init),
    .done_write (done_write),
    .done_crono (done_crono),
    .done_read  (done_read),
    .clr_err    (clr_err),
    .gnt_init   (gnt_init),
    .gnt_write  (gnt_write),
    .gnt_crono  (gnt_crono),
    .gnt_read   (gnt_read),
    .owner      (owner),
    .bus_busy   (bus_busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected grant interval. gap < 0 means "not checked".
  typedef struct {
    int   who;
    int   hold;
    logic err;
    int   gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  logic err_m  = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- monitor ----------------
  logic [3:0] prev_g = 4'b0;
  int         hold_obs = 0;
  int         low_cnt = 0;
  int         gap_obs = 0;
  int         cur_who = 0;

  function automatic int idx_of(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    logic [3:0] g;
    exp_t e;
    g = {gnt_read, gnt_crono, gnt_write, gnt_init};
    if (!reset) begin
      prev_g  = 4'b0;
      low_cnt = 0;
    end else begin
      chk("onehot0", ($countones(g) <= 1) ? 1 : 0, 1);
      chk("bus_busy", int'(bus_busy), int'(|g));
      if (prev_g == 4'b0 && g != 4'b0) begin
        cur_who  = idx_of(g);
        hold_obs = 1;
        gap_obs  = low_cnt;
        chk("owner_out", int'(owner), cur_who);
      end else if (prev_g != 4'b0 && g == prev_g) begin
        hold_obs++;
      end else if (prev_g != 4'b0 && g != 4'b0) begin
        chk("switch_without_gap", int'(g), int'(prev_g));
      end else if (prev_g != 4'b0 && g == 4'b0) begin
        if (q.size() == 0) begin
          chk("unexpected_grant_owner", cur_who, -1);
        end else begin
          e = q.pop_front();
          chk("grant_owner", cur_who, e.who);
          chk("grant_hold", hold_obs, e.hold);
          chk("timeout_err", int'(timeout_err), int'(e.err));
          if (e.gap >= 0) chk("grant_gap", gap_obs, e.gap);
          $display("txn owner=%0d hold=%0d gap=%0d err=%0d", cur_who, hold_obs, gap_obs, timeout_err);
        end
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      prev_g = g;
    end
  end

  // ---------------- driver ----------------
  task automatic set_done(input int m);
    case (m)
      0: done_init  = 1'b1;
      1: done_write = 1'b1;
      2: done_crono = 1'b1;
      default: done_read = 1'b1;
    endcase
  endtask

  task automatic clear_reqs();
    req_write = 1'b0;
    req_crono = 1'b0;
    req_read  = 1'b0;
  endtask

  // Waits (bounded) until a grant is visible; returns at grant cycle 1.
  task automatic wait_grant(output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_busy && n < 40);
    ok = bus_busy;
    if (!ok) chk("grant_wait", int'(bus_busy), 1);
  endtask

  // Acts as the granted machine: done in grant cycle k (k > TIMEOUT: never),
  // an optional non-owner done in cycle spur, optional clr_err in the final
  // timeout cycle. Returns on the first cycle after the grant falls.
  task automatic run_grant(input int who, input int k, input int spur,
                           input bit clr_end, input bit noise);
    int sw;
    sw = (who + 1 + int'($urandom % 3)) % 4;
    for (int c = 1; c <= TIMEOUT; c++) begin
      if (c == k) set_done(who);
      if (c == spur) set_done(sw);
      if (clr_end && c == TIMEOUT) clr_err = 1'b1;
      if (noise) begin
        req_write = $urandom % 2;
        req_crono = $urandom % 2;
        req_read  = $urandom % 2;
      end
      @(negedge clk);
      done_init  = 1'b0;
      done_write = 1'b0;
      done_crono = 1'b0;
      done_read  = 1'b0;
      clr_err    = 1'b0;
      if (c >= k) break;
    end
    if (noise) clear_reqs();
  endtask

  task automatic next_txn(input int t);
    int   w, wt, who, k, spur, hold, gap;
    logic [2:0] r;
    bit   clr_end, ok;
    exp_t e;
    wt = 0;
    if (t == 2 || ($urandom % 3) == 0) begin
      clr_err = 1'b1;
      err_m   = 1'b0;
      @(negedge clk);
      clr_err = 1'b0;
      chk("clr_err_clears", int'(timeout_err), 0);
      wt = 1;
    end
    w = int'($urandom % 4);
    repeat (w) @(negedge clk);
    wt += w;
    r = 3'($urandom_range(1, 7));
    who = r[0] ? 1 : (r[1] ? 2 : 3);
    if (t == 0)      k = TIMEOUT;
    else if (t == 1) k = TIMEOUT + 1;
    else             k = int'($urandom_range(1, TIMEOUT + 2));
    clr_end = (k > TIMEOUT) && (t == 1 || ($urandom % 2) == 1);
    if (k > TIMEOUT) err_m = 1'b1;
    hold = (k < TIMEOUT) ? k : TIMEOUT;
    gap  = (wt + 1 > TURN_CYCLES + 1) ? wt + 1 : TURN_CYCLES + 1;
    spur = (($urandom % 2) == 1) ? int'($urandom_range(1, hold)) : 0;
    e = '{who, hold, err_m, gap};
    q.push_back(e);
    req_write = r[0];
    req_crono = r[1];
    req_read  = r[2];
    wait_grant(ok);
    if (!ok) begin
      clear_reqs();
      return;
    end
    run_grant(who, k, spur, clr_end, 1'b1);
  endtask

  initial begin
    int   k0;
    bit   ok;
    exp_t e;
    reset = 1'b0;
    clr_err = 1'b0;
    clear_reqs();
    done_init = 1'b0; done_write = 1'b0; done_crono = 1'b0; done_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_bus_busy", int'(bus_busy), 0);
    chk("reset_owner", int'(owner), 0);
    chk("reset_timeout_err", int'(timeout_err), 0);

    // Boot: init granted one edge after release, no request needed.
    k0 = int'($urandom_range(1, TIMEOUT));
    e = '{0, k0, 1'b0, -1};
    q.push_back(e);
    reset = 1'b1;
    @(negedge clk);
    chk("boot_gnt_init", int'(gnt_init), 1);
    chk("boot_owner", int'(owner), 0);
    run_grant(0, k0, 0, 1'b0, 1'b0);

    for (int t = 0; t < NTXN; t++) next_txn(t);

    // Asynchronous reset in the middle of a write grant.
    repeat (TURN_CYCLES + 2) @(negedge clk);
    q.delete();
    req_write = 1'b1;
    wait_grant(ok);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_gnt_write", int'(gnt_write), 0);
    chk("async_rst_bus_busy", int'(bus_busy), 0);
    chk("async_rst_owner", int'(owner), 0);
    chk("async_rst_timeout_err", int'(timeout_err), 0);
    err_m = 1'b0;
    repeat (2) @(negedge clk);
    e = '{0, 3, 1'b0, -1};
    q.push_back(e);
    e = '{1, 2, 1'b0, TURN_CYCLES + 1};
    q.push_back(e);
    reset = 1'b1;
    @(negedge clk);
    chk("rerun_gnt_init", int'(gnt_init), 1);
    chk("rerun_gnt_write", int'(gnt_write), 0);
    run_grant(0, 3, 0, 1'b0, 1'b0);
    wait_grant(ok);
    chk("after_init_owner", int'(owner), 1);
    run_grant(1, 2, 0, 1'b0, 1'b0);
    req_write = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
